mult_unit: RTL and testbench

Iterative unsigned multiplier with architectural HI/LO registers. It consumes the mult_enable, sfmux_high and sf2reg controls from the ALU auxiliary decoder, and computes MULTU products over WIDTH cycles using radix-2 shift-add. It returns HI or LO for MFHI/MFLO, and asserts stall to freeze the pipeline while a product is in flight.

---
 rtl/mult_unit.sv | 93 +++++++++
 tb/tb_mult_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add unsigned multiplier with HI/LO registers.
// Takes WIDTH cycles per product and requests a pipeline stall while one is in flight.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mult_enable,
  input  logic             sfmux_high,
  input  logic             sf2reg,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] sf_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 done_q;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mult_enable) begin
            state_q  <= RUN;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // HI/LO change only here, so readers never see a partial product
          if (cnt_q == LAST) begin
            hi_q    <= acc_d[2*WIDTH-1:WIDTH];
            lo_q    <= acc_d[WIDTH-1:0];
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q == RUN);
  assign stall  = busy & (sf2reg | mult_enable);
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign sf_out = sfmux_high ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Bench for mult_unit: product model with per-cycle compare plus
// directed vectors with literal expected values.
module tb_mult_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mult_enable = 1'b0;
  logic         sfmux_high = 1'b0;
  logic         sf2reg = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo, sf_out;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [W-1:0]   hi_m = '0;
  logic [W-1:0]   lo_m = '0;
  logic [2*W-1:0] prod_m = '0;
  logic           done_m = 1'b0;
  int             left_m = 0;

  mult_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .mult_enable(mult_enable),
    .sfmux_high(sfmux_high), .sf2reg(sf2reg), .a(a), .b(b),
    .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo), .sf_out(sf_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Model: a product is a*b, ready WIDTH edges after an accepted start
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_m   = '0;
      lo_m   = '0;
      done_m = 1'b0;
      left_m = 0;
    end else begin
      done_m = 1'b0;
      if (left_m > 0) begin
        left_m = left_m - 1;
        if (left_m == 0) begin
          hi_m   = prod_m[2*W-1:W];
          lo_m   = prod_m[W-1:0];
          done_m = 1'b1;
        end
      end else if (mult_enable) begin
        prod_m = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        left_m = W;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_busy", busy, left_m > 0);
      chk("m_done", done, done_m);
      chk("m_stall", stall, (left_m > 0) & (sf2reg | mult_enable));
      chk("m_hi", hi, hi_m);
      chk("m_lo", lo, lo_m);
      chk("m_sf", sf_out, sfmux_high ? hi_m : lo_m);
    end
  end

  task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(posedge clk);
    #1;
    a = av;
    b = bv;
    mult_enable = 1'b1;
    @(posedge clk);
    start_cyc = cyc + 1;
    #1;
    mult_enable = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
    else chk({nm, "_lat"}, cyc - start_cyc, W);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_lo", lo, 0);
    end

    start(32'd3, 32'd5);
    wait_done("basic");
    chk("basic_hi", hi, 64'h0);
    chk("basic_lo", lo, 64'hF);
    @(posedge clk);
    #1 sfmux_high = 1'b1;
    #1 chk("basic_sfhi", sf_out, 0);
    sfmux_high = 1'b0;
    #1 chk("basic_sflo", sf_out, 64'hF);

    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("max");
    chk("max_hi", hi, 64'hFFFF_FFFE);
    chk("max_lo", lo, 64'h1);

    start(32'h8000_0000, 32'd2);
    wait_done("msb");
    chk("msb_hi", hi, 64'h1);
    chk("msb_lo", lo, 64'h0);

    start(32'd0, 32'd5);
    wait_done("zero");
    chk("zero_lo", lo, 64'h0);

    start(32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    sf2reg = 1'b1;
    sfmux_high = 1'b1;
    @(negedge clk);
    chk("ilk_stall_rd", stall, 1);
    chk("ilk_old_hi", sf_out, 64'h0);
    @(posedge clk);
    #1;
    sf2reg = 1'b0;
    sfmux_high = 1'b0;
    a = 32'd1;
    b = 32'd1;
    mult_enable = 1'b1;
    @(negedge clk);
    chk("ilk_stall_st", stall, 1);
    chk("ilk_old_lo", sf_out, 64'h0);
    @(posedge clk);
    #1 mult_enable = 1'b0;
    wait_done("ilk");
    chk("ilk_lo", lo, 64'd63);

    start(32'd10, 32'd10);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) chk("abort_nodone", done, 0);
    end
    chk("abort_idle", busy, 0);

    start(32'd2, 32'd3);
    wait_done("b2b1");
    chk("b2b1_lo", lo, 64'd6);
    a = 32'd4;
    b = 32'd4;
    mult_enable = 1'b1;
    @(posedge clk);
    start_cyc = cyc + 1;
    #1 mult_enable = 1'b0;
    @(negedge clk);
    chk("b2b_hold", lo, 64'd6);
    wait_done("b2b2");
    chk("b2b2_lo", lo, 64'd16);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
